pio_read_arbiter: RTL
=====================

PIO_READ_ARBITER -- requirements
Module: pio_read_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 32, PIO read data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  NUM_REQ  per-requester read request, level, held until ack.
REQ-006 SHALL have port req_addr  input  2*NUM_REQ  per-requester 2-bit PIO address (requester i at bits [2i+1:2i]).
REQ-007 SHALL have port ack  output  NUM_REQ  one-cycle completion pulse, one-hot.
REQ-008 SHALL have port rdata  output  DATA_W  read result, valid in the ack cycle, held until next completion.
REQ-009 SHALL have port pio_address  output  2  address to the shared PIO read slave.
REQ-010 SHALL have port pio_readdata  input  DATA_W  PIO read data, registered in the slave one cycle after pio_address.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, CAPTURE, RESP.
REQ-013 SHALL, in IDLE or RESP, with any eligible req high: grant, latch grant index and req_addr of the winner, and go to ISSUE; with no eligible req: go to IDLE.
REQ-014 SHALL move ISSUE -> CAPTURE -> RESP unconditionally, one cycle each.
REQ-015 SHALL arbitrate round-robin: search starts at pointer ptr and ascends modulo NUM_REQ; the first eligible req wins; after a grant to k, ptr = (k+1) mod NUM_REQ.
REQ-016 SHALL treat all requesters as eligible in IDLE; in RESP it SHALL mask the requester currently being acked.
REQ-017 SHALL drive pio_address = latched address in ISSUE and CAPTURE, and 2'b00 in IDLE and RESP.
REQ-018 SHALL register pio_readdata into rdata at the end of CAPTURE.
REQ-019 SHALL assert ack[k] for exactly the RESP cycle, for the granted k only.
REQ-020 SHALL keep fixed latency: req first seen in IDLE at cycle T -> ack at T+3; back-to-back grants issued from RESP give one completion every 3 cycles.
REQ-021 SHALL ignore req_addr changes after grant; the latched address is used.
REQ-022 SHALL complete and ack a granted transaction even if its req drops before RESP.
REQ-023 SHALL ignore req changes in ISSUE and CAPTURE; no pre-emption.
REQ-024 SHALL hold rdata between completions; it SHALL change only at the end of CAPTURE.

Reset
REQ-025 SHALL, on reset assertion (any state, asynchronously): state=IDLE, ptr=0, ack=0, rdata=0, pio_address=0, busy=0, latched index/address=0.
REQ-026 SHALL discard an in-flight transaction on reset; no ack is issued for it after release.
REQ-027 SHALL begin arbitration on the first rising edge with reset low.

Verification
REQ-028 Single read: req=0001, req_addr[1:0]=0, pio slave returns 0xDEADBEEF -> pio_address=0 for 2 cycles, ack=0001 at T+3, rdata=0xDEADBEEF.
REQ-029 Round-robin: req=1111 held, requesters deassert req on ack -> acks in order 0001,0010,0100,1000, spaced 3 cycles, busy stays high throughout.
REQ-030 Fairness/mask: req0 and req2 held permanently -> grants alternate 0,2,0,2; req0 never acked in consecutive slots.
REQ-031 Address latch: grant requester 1 with addr=2, change req_addr to 3 in ISSUE -> pio_address stays 2 through CAPTURE.
REQ-032 Dropped request: req3 deasserted in CAPTURE -> ack=1000 still pulses in RESP with captured data.
REQ-033 Reset mid-op: assert reset in CAPTURE -> outputs 0 immediately, no ack after release, next grant starts search at requester 0.

Source files
------------

// File: rtl/pio_read_arbiter.sv
// Purpose: round-robin arbiter that shares one PIO read slave among NUM_REQ requesters.
// Latency: request seen in IDLE at cycle T is acked at T+3; grants from RESP give one completion every 3 cycles.
// Backpressure: requests are level-held until their one-cycle ack; no pre-emption once a grant is issued.
//
// Ports:
//   clk          single clock, rising edge
//   reset        asynchronous, active-high reset
//   req          per-requester read request (level)
//   req_addr     per-requester 2-bit address, requester i at [2i+1:2i]
//   ack          one-hot completion pulse, asserted in the RESP cycle
//   rdata        read result, valid with ack and held until the next completion
//   pio_address  address to the shared PIO slave (0 when not addressing)
//   pio_readdata slave data, registered by the slave one cycle after pio_address
//   busy         high whenever the arbiter is not IDLE
module pio_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [2*NUM_REQ-1:0] req_addr,
  output logic [NUM_REQ-1:0]   ack,
  output logic [DATA_W-1:0]    rdata,
  output logic [1:0]           pio_address,
  input  logic [DATA_W-1:0]    pio_readdata,
  output logic                 busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   grant_idx;
  logic [1:0]         addr_q;
  logic [NUM_REQ-1:0] eligible;
  logic               win_vld;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   ptr_nxt;
  logic [1:0]         win_addr;
  logic               arb_en;
  int                 cand;

  // A new grant can only be issued while the slave is free: IDLE or the ack cycle.
  assign arb_en = (state == IDLE) || (state == RESP);

  // The requester being acked this cycle is still holding req; mask it so the
  // slot rotates instead of re-granting the same requester.
  always_comb begin
    eligible = req;
    if (state == RESP) eligible[grant_idx] = 1'b0;
  end

  // Round-robin search from ptr upward, wrapping at NUM_REQ.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_vld && eligible[IDX_W'(cand)]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(cand);
      end
    end
  end

  assign ptr_nxt = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);

  always_comb begin
    win_addr = 2'b00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == win_idx) win_addr = req_addr[2*i +: 2];
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RESP: state_nxt = win_vld ? ISSUE : IDLE;
      ISSUE:      state_nxt = CAPTURE;
      CAPTURE:    state_nxt = RESP;
      default:    state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from state so reset clears them without waiting for a clock.
  always_comb begin
    busy        = (state != IDLE);
    pio_address = ((state == ISSUE) || (state == CAPTURE)) ? addr_q : 2'b00;
    ack         = '0;
    if (state == RESP) ack[grant_idx] = 1'b1;
  end

  // Grant bookkeeping and read-data capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      grant_idx <= '0;
      addr_q    <= 2'b00;
      rdata     <= '0;
    end else begin
      if (arb_en && win_vld) begin
        grant_idx <= win_idx;
        addr_q    <= win_addr;
        ptr       <= ptr_nxt;
      end
      // Slave data for addr_q is present during CAPTURE.
      if (state == CAPTURE) rdata <= pio_readdata;
    end
  end

endmodule
